// File: rtl/mem_access_master.sv
// Load/store initiator for the byte-addressed data memory. Aligned accesses are issued once;
// misaligned halfword/word accesses are split into byte accesses and reassembled.
module mem_access_master #(
   parameter logic [31:0] START_ADDRESS = 32'h01000000,
   parameter logic [31:0] MEM_SIZE      = 32'd1048576
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [31:0] req_addr,
   input  logic [1:0]  req_size,
   input  logic        req_unsigned,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_err,
   output logic [31:0] mem_address,
   output logic [31:0] mem_data_in,
   output logic        mem_w_enable,
   output logic [1:0]  mem_access_size,
   output logic        mem_RdUn,
   input  logic [31:0] mem_data_out
);
   typedef enum logic [1:0] {IDLE, ACCESS, SPLIT, RESP} state_t;

   state_t      state;
   logic        wr, uns, half;
   logic [31:0] wdata, asm_q, asm_nx, split_ext;
   logic [1:0]  k, kn;
   logic [2:0]  req_nb;
   logic [32:0] last_byte, mem_end;
   logic        range_err, req_aligned, split_last;

   assign req_ready = (state == IDLE) && reset_n;

   always_comb begin
      req_nb = 3'd4;
      if (req_size == 2'b00)      req_nb = 3'd1;
      else if (req_size == 2'b01) req_nb = 3'd2;
   end

   // 33-bit bounds so an access touching the very top of the address space cannot wrap
   assign last_byte   = {1'b0, req_addr} + {30'b0, req_nb} - 33'd1;
   assign mem_end     = {1'b0, START_ADDRESS} + {1'b0, MEM_SIZE};
   assign range_err   = (req_addr < START_ADDRESS) || (last_byte >= mem_end);
   assign req_aligned = (req_size == 2'b00) ||
                        (req_size == 2'b01 && !req_addr[0]) ||
                        (req_size[1] && req_addr[1:0] == 2'b00);

   assign kn         = k + 2'd1;
   assign split_last = half ? (k == 2'd1) : (k == 2'd3);

   always_comb begin
      asm_nx = asm_q;
      asm_nx[{k, 3'b000} +: 8] = mem_data_out[7:0];
      split_ext = asm_nx;
      if (half) split_ext = uns ? {16'h0, asm_nx[15:0]} : {{16{asm_nx[15]}}, asm_nx[15:0]};
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state           <= IDLE;
         resp_valid      <= 1'b0;
         resp_err        <= 1'b0;
         resp_rdata      <= 32'h0;
         mem_address     <= 32'h0;
         mem_data_in     <= 32'h0;
         mem_w_enable    <= 1'b0;
         mem_access_size <= 2'b10;
         mem_RdUn        <= 1'b0;
         wr              <= 1'b0;
         uns             <= 1'b0;
         half            <= 1'b0;
         wdata           <= 32'h0;
         asm_q           <= 32'h0;
         k               <= 2'd0;
      end else begin
         case (state)
            IDLE: if (req_valid) begin
               wr    <= req_write;
               uns   <= req_unsigned;
               half  <= (req_size == 2'b01);
               wdata <= req_wdata;
               k     <= 2'd0;
               asm_q <= 32'h0;
               if (range_err) begin
                  state      <= RESP;
                  resp_valid <= 1'b1;
                  resp_err   <= 1'b1;
                  resp_rdata <= 32'h0;
               end else begin
                  mem_address  <= req_addr;
                  mem_w_enable <= req_write;
                  if (req_aligned) begin
                     state           <= ACCESS;
                     // size 2'b11 is issued to memory as a plain word
                     mem_access_size <= req_size[1] ? 2'b10 : req_size;
                     mem_RdUn        <= req_unsigned;
                     mem_data_in     <= req_write ? req_wdata : 32'h0;
                  end else begin
                     state           <= SPLIT;
                     mem_access_size <= 2'b00;
                     mem_RdUn        <= 1'b1;
                     mem_data_in     <= req_write ? {24'h0, req_wdata[7:0]} : 32'h0;
                  end
               end
            end
            ACCESS: begin
               state        <= RESP;
               resp_valid   <= 1'b1;
               resp_err     <= 1'b0;
               resp_rdata   <= wr ? 32'h0 : mem_data_out;
               mem_w_enable <= 1'b0;
               mem_data_in  <= 32'h0;
            end
            SPLIT: begin
               asm_q <= asm_nx;
               if (split_last) begin
                  state        <= RESP;
                  resp_valid   <= 1'b1;
                  resp_err     <= 1'b0;
                  resp_rdata   <= wr ? 32'h0 : split_ext;
                  mem_w_enable <= 1'b0;
                  mem_data_in  <= 32'h0;
               end else begin
                  k           <= kn;
                  mem_address <= mem_address + 32'd1;
                  mem_data_in <= wr ? {24'h0, wdata[{kn, 3'b000} +: 8]} : 32'h0;
               end
            end
            RESP: begin
               state      <= IDLE;
               resp_valid <= 1'b0;
               resp_err   <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_mem_access_master.sv
// Bench for mem_access_master: byte memory model, transaction-level reference model checked
// every cycle, directed scenarios with literal expectations, then randomized traffic.
module tb_mem_access_master;
   localparam logic [31:0] START = 32'h01000000;
   localparam logic [31:0] MSIZE = 32'd1048576;
   localparam int          WIN   = 4096;

   logic        clk = 1'b0, reset_n = 1'b0;
   logic        req_valid, req_ready, req_write, req_unsigned;
   logic [31:0] req_addr, req_wdata;
   logic [1:0]  req_size;
   logic        resp_valid, resp_err;
   logic [31:0] resp_rdata;
   logic [31:0] mem_address, mem_data_in, mem_data_out;
   logic        mem_w_enable, mem_RdUn;
   logic [1:0]  mem_access_size;

   int total = 0, bad = 0, cyc = 0;

   mem_access_master #(.START_ADDRESS(START), .MEM_SIZE(MSIZE)) dut (
      .clk(clk), .reset_n(reset_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_addr(req_addr), .req_size(req_size), .req_unsigned(req_unsigned),
      .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
      .mem_address(mem_address), .mem_data_in(mem_data_in), .mem_w_enable(mem_w_enable),
      .mem_access_size(mem_access_size), .mem_RdUn(mem_RdUn), .mem_data_out(mem_data_out)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic int nbytes(input logic [1:0] s);
      return (s == 2'b00) ? 1 : (s == 2'b01) ? 2 : 4;
   endfunction

   function automatic logic [31:0] extend(input logic [31:0] v, input int nb, input logic un);
      if (nb == 1) return un ? {24'h0, v[7:0]} : {{24{v[7]}}, v[7:0]};
      if (nb == 2) return un ? {16'h0, v[15:0]} : {{16{v[15]}}, v[15:0]};
      return v;
   endfunction

   function automatic longint widx(input logic [31:0] a);
      return longint'({32'h0, a}) - longint'({32'h0, START});
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Data memory: only a window at START is backed; everything else reads 0 and drops writes
   logic [7:0]  dmem    [0:WIN-1];
   logic [7:0]  ref_mem [0:WIN-1];
   logic        pre_we = 1'b0;
   int          pre_idx = 0;
   logic [7:0]  pre_byte = 8'h0;
   longint      mi, ci;
   logic [31:0] mrd;

   always @(posedge clk) begin
      if (pre_we) dmem[pre_idx] <= pre_byte;
      else if (mem_w_enable)
         for (int j = 0; j < 4; j++)
            if (j < nbytes(mem_access_size)) begin
               mi = widx(mem_address) + j;
               if (mi >= 0 && mi < WIN) dmem[int'(mi)] <= mem_data_in[8*j +: 8];
            end
   end

   always_comb begin
      mrd = 32'h0;
      ci  = 0;
      for (int j = 0; j < 4; j++) begin
         ci = widx(mem_address) + j;
         if (ci >= 0 && ci < WIN) mrd[8*j +: 8] = dmem[int'(ci)];
      end
      mem_data_out = extend(mrd, nbytes(mem_access_size), mem_RdUn);
   end

   function automatic logic [31:0] ref_load(input logic [31:0] a, input int nb, input logic un);
      logic [31:0] v = 32'h0;
      longint i;
      for (int j = 0; j < nb; j++) begin
         i = widx(a) + j;
         if (i >= 0 && i < WIN) v[8*j +: 8] = ref_mem[int'(i)];
      end
      return extend(v, nb, un);
   endfunction

   // Reference model: one outstanding transaction described by its accept cycle,
   // the list of memory accesses it must issue and its response.
   bit          t_act = 1'b0, t_err, t_split, t_we, busy, exp_rv;
   int          t_a, t_lat, t_nacc, t_nb, m, idx;
   logic [31:0] t_rd, last_addr = 32'h0;
   logic [31:0] e_addr [4];
   logic [31:0] e_dat  [4];
   logic [1:0]  e_sz   [4];
   logic        e_un   [4];
   longint      wi;

   always @(negedge clk) begin
      if (!reset_n) begin
         chk("reset_ctl", {25'b0, req_ready, resp_valid, resp_err, mem_w_enable, mem_RdUn, mem_access_size}, 32'h2);
         chk("reset_addr", mem_address, 32'h0);
         chk("reset_wdata", mem_data_in, 32'h0);
         chk("reset_rdata", resp_rdata, 32'h0);
         t_act = 1'b0;
         last_addr = 32'h0;
      end else begin
         m = cyc;
         busy = t_act && (m >= t_a) && (m <= t_a + t_lat - 1);
         chk("req_ready", {31'b0, req_ready}, {31'b0, !busy});
         idx = m - t_a;
         if (t_act && idx >= 0 && idx < t_nacc) begin
            chk("acc_we", {31'b0, mem_w_enable}, {31'b0, t_we});
            chk("acc_addr", mem_address, e_addr[idx]);
            chk("acc_size", {30'b0, mem_access_size}, {30'b0, e_sz[idx]});
            chk("acc_rdun", {31'b0, mem_RdUn}, {31'b0, e_un[idx]});
            if (t_we) begin
               if (t_split) chk("wdata_byte", {24'b0, mem_data_in[7:0]}, e_dat[idx]);
               else         chk("wdata", mem_data_in, e_dat[idx]);
               for (int j = 0; j < (t_split ? 1 : t_nb); j++) begin
                  wi = widx(e_addr[idx]) + j;
                  if (wi >= 0 && wi < WIN) ref_mem[int'(wi)] = e_dat[idx][8*j +: 8];
               end
            end
            last_addr = e_addr[idx];
         end else begin
            chk("idle_we", {31'b0, mem_w_enable}, 32'h0);
            chk("idle_wdata", mem_data_in, 32'h0);
            chk("addr_hold", mem_address, last_addr);
         end
         exp_rv = t_act && (m == t_a + t_lat - 1);
         chk("resp_valid", {31'b0, resp_valid}, {31'b0, exp_rv});
         if (exp_rv) begin
            chk("resp_err", {31'b0, resp_err}, {31'b0, t_err});
            chk("resp_rdata", resp_rdata, t_rd);
         end
         if (req_valid && req_ready) begin
            t_act   = 1'b1;
            t_a     = m + 1;
            t_nb    = nbytes(req_size);
            t_we    = req_write;
            t_err   = (req_addr < START) ||
                      (longint'({32'h0, req_addr}) + t_nb - 1 >= longint'({32'h0, START}) + longint'({32'h0, MSIZE}));
            t_split = !t_err && ((req_addr % 32'(t_nb)) != 32'h0);
            if (t_err) t_nacc = 0;
            else if (!t_split) begin
               t_nacc    = 1;
               e_addr[0] = req_addr;
               e_sz[0]   = (t_nb == 4) ? 2'b10 : 2'(t_nb - 1);
               e_un[0]   = req_unsigned;
               e_dat[0]  = req_wdata;
            end else begin
               t_nacc = t_nb;
               for (int j = 0; j < t_nb; j++) begin
                  e_addr[j] = req_addr + 32'(j);
                  e_sz[j]   = 2'b00;
                  e_un[j]   = 1'b1;
                  e_dat[j]  = {24'h0, req_wdata[8*j +: 8]};
               end
            end
            t_lat = t_nacc + 1;
            t_rd  = (t_err || req_write) ? 32'h0 : ref_load(req_addr, t_nb, req_unsigned);
         end
      end
   end

   task automatic poke(input int i, input logic [7:0] b);
      pre_we = 1'b1; pre_idx = i; pre_byte = b; ref_mem[i] = b;
      @(posedge clk); #1;
      pre_we = 1'b0;
   endtask

   task automatic send(input logic w, input logic [31:0] a, input logic [1:0] s,
                       input logic u, input logic [31:0] d);
      bit ok = 1'b0;
      @(posedge clk); #1;
      req_write = w; req_addr = a; req_size = s; req_unsigned = u; req_wdata = d; req_valid = 1'b1;
      for (int n = 0; n < 50; n++) begin
         @(negedge clk);
         if (req_ready) begin ok = 1'b1; break; end
      end
      if (!ok) begin total++; bad++; $display("FAIL accept_timeout: req_ready never seen"); end
      @(posedge clk); #1;
      req_valid = 1'b0;
   endtask

   task automatic wait_resp(output logic [31:0] rd, output logic e, output int lat);
      lat = 0; rd = 32'h0; e = 1'b0;
      for (int n = 1; n <= 20; n++) begin
         @(negedge clk);
         if (resp_valid) begin rd = resp_rdata; e = resp_err; lat = n; break; end
      end
      if (lat == 0) begin total++; bad++; $display("FAIL resp_timeout: no resp_valid within 20 cycles"); end
   endtask

   task automatic req(input logic w, input logic [31:0] a, input logic [1:0] s, input logic u,
                      input logic [31:0] d, output logic [31:0] rd, output logic e, output int lat);
      send(w, a, s, u, d);
      wait_resp(rd, e, lat);
   endtask

   logic [31:0] rd, a;
   logic        e;
   int          lat, a2, r1, nrv, nm, r;

   initial begin
      req_valid = 1'b0; req_write = 1'b0; req_addr = 32'h0; req_size = 2'b00;
      req_unsigned = 1'b0; req_wdata = 32'h0;
      for (int i = 0; i < WIN; i++) poke(i, (i < 512) ? 8'($urandom) : 8'h00);
      poke(4, 8'hEF); poke(5, 8'hBE); poke(6, 8'hAD); poke(7, 8'hDE);
      poke(1, 8'h34); poke(2, 8'h92); poke(32'h83, 8'h5A); poke(32'h84, 8'hA5);
      #2 reset_n = 1'b1;

      req(1'b0, START + 32'h4, 2'b10, 1'b0, 32'h0, rd, e, lat);
      chk("t1_rdata", rd, 32'hDEADBEEF); chk("t1_err", {31'b0, e}, 32'h0); chk("t1_lat", lat, 32'd2);

      req(1'b0, START + 32'h1, 2'b01, 1'b0, 32'h0, rd, e, lat);
      chk("t2_signed", rd, 32'hFFFF9234); chk("t2_lat", lat, 32'd3);
      req(1'b0, START + 32'h1, 2'b01, 1'b1, 32'h0, rd, e, lat);
      chk("t2_unsigned", rd, 32'h00009234);

      req(1'b1, START + 32'h3, 2'b10, 1'b0, 32'h11223344, rd, e, lat);
      chk("t3_lat", lat, 32'd5); chk("t3_rdata", rd, 32'h0);
      chk("t3_bytes", {dmem[6], dmem[5], dmem[4], dmem[3]}, 32'h11223344);
      req(1'b0, START + 32'h3, 2'b10, 1'b0, 32'h0, rd, e, lat);
      chk("t3_readback", rd, 32'h11223344);

      req(1'b0, 32'h00FFFFFC, 2'b10, 1'b0, 32'h0, rd, e, lat);
      chk("t4_lo_err", {31'b0, e}, 32'h1); chk("t4_lo_lat", lat, 32'd1); chk("t4_lo_rd", rd, 32'h0);
      req(1'b1, 32'h010FFFFE, 2'b10, 1'b0, 32'hFFFFFFFF, rd, e, lat);
      chk("t4_hi_err", {31'b0, e}, 32'h1); chk("t4_hi_lat", lat, 32'd1); chk("t4_hi_rd", rd, 32'h0);

      // reset during the third byte of a split word store
      send(1'b1, START + 32'h81, 2'b10, 1'b0, 32'hAABBCCDD);
      @(posedge clk); @(posedge clk); #2 reset_n = 1'b0;
      #1;
      chk("t5_async_we", {31'b0, mem_w_enable}, 32'h0);
      chk("t5_async_addr", mem_address, 32'h0);
      repeat (2) @(posedge clk);
      #3 reset_n = 1'b1;
      @(negedge clk);
      chk("t5_ready", {31'b0, req_ready}, 32'h1);
      nrv = 0;
      repeat (6) begin @(negedge clk); if (resp_valid) nrv++; end
      chk("t5_no_resp", nrv, 32'd0);
      chk("t5_bytes", {dmem[32'h84], dmem[32'h83], dmem[32'h82], dmem[32'h81]}, 32'hA55ACCDD);

      // back-to-back with req_valid held high
      @(posedge clk); #1;
      req_write = 1'b1; req_addr = START + 32'h40; req_size = 2'b10; req_unsigned = 1'b0;
      req_wdata = 32'h0BADF00D; req_valid = 1'b1;
      for (int n = 0; n < 20; n++) begin @(negedge clk); if (req_ready) break; end
      @(posedge clk); #1;
      req_write = 1'b0; req_wdata = 32'h0;
      r1 = -100;
      for (int n = 0; n < 20; n++) begin @(negedge clk); if (resp_valid) begin r1 = cyc; break; end end
      a2 = -1;
      for (int n = 0; n < 20; n++) begin @(negedge clk); if (req_ready) begin a2 = cyc + 1; break; end end
      chk("t6_gap", a2 - r1, 32'd2);
      @(posedge clk); #1 req_valid = 1'b0;
      wait_resp(rd, e, lat);
      chk("t6_rdata", rd, 32'h0BADF00D); chk("t6_lat", lat, 32'd2);

      for (int i = 0; i < 250; i++) begin
         r = $urandom_range(0, 99);
         if (r < 8)       a = START - 32'($urandom_range(1, 8));
         else if (r < 16) a = START + MSIZE - 32'($urandom_range(1, 6));
         else             a = START + 32'($urandom_range(0, 200));
         req(1'($urandom), a, 2'($urandom), 1'($urandom), $urandom, rd, e, lat);
         repeat ($urandom_range(0, 2)) @(posedge clk);
      end

      nm = 0;
      for (int i = 0; i < WIN; i++) if (dmem[i] !== ref_mem[i]) nm++;
      chk("mem_image", nm, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
